// File: rtl/ns_pkt_pkg.sv
// rtl/ns_pkt_pkg.sv - packet types, lengths and beat-count helpers shared by tx and rx sides
package ns_pkt_pkg;

  typedef enum logic [1:0] {
    PKT_FD  = 2'd0,
    PKT_MD  = 2'd1,
    PKT_FC  = 2'd2,
    PKT_BAD = 2'd3
  } pkt_type_e;

  localparam int FD_LEN = 4160;
  localparam int MD_LEN = 192;
  localparam int FC_LEN = 68;

  function automatic int pkt_len(input pkt_type_e t);
    case (t)
      PKT_FD:  return FD_LEN;
      PKT_MD:  return MD_LEN;
      default: return FC_LEN;
    endcase
  endfunction

  function automatic int beats_per_pkt(input pkt_type_e t, input int bytes_per_beat);
    return (pkt_len(t) + bytes_per_beat - 1) / bytes_per_beat;
  endfunction

endpackage

// File: rtl/ns_txpkt_beat_fmt.sv
// rtl/ns_txpkt_beat_fmt.sv - combinational beat formatter: tdata/tkeep/tlast from type, beat index, sequence
module ns_txpkt_beat_fmt
  import ns_pkt_pkg::*;
#(
  parameter int DW = 512
) (
  input  pkt_type_e         pkt_type,
  input  logic [7:0]        beat_idx,
  input  logic [31:0]       seq,
  output logic [DW-1:0]     tdata,
  output logic [DW/8-1:0]   tkeep,
  output logic              tlast
);

  localparam int BPB = DW / 8;

  int last_beat;
  int rem;

  always_comb begin
    last_beat = beats_per_pkt(pkt_type, BPB) - 1;
    rem       = pkt_len(pkt_type) % BPB;
    tlast     = (int'(beat_idx) == last_beat);
    for (int i = 0; i < BPB; i++) begin
      tkeep[i] = !tlast || (rem == 0) || (i < rem);
    end
    tdata = '0;
    if (beat_idx == 8'd0) begin
      tdata[31:0]  = seq;
      tdata[39:32] = {6'd0, pkt_type};
    end else begin
      for (int w = 0; w < DW / 32; w++) begin
        tdata[32*w +: 32] = {24'd0, beat_idx};
      end
    end
    // Bytes past the end of the packet are forced to zero.
    for (int i = 0; i < BPB; i++) begin
      if (!tkeep[i]) tdata[8*i +: 8] = 8'd0;
    end
  end

endmodule

// File: rtl/ns_txpkt_generator.sv
// rtl/ns_txpkt_generator.sv - command-driven test packet generator toward CMAC; NS_TXPKT_STATS_EN enables sent counters
module ns_txpkt_generator
  import ns_pkt_pkg::*;
#(
  parameter int DW  = 512,
  parameter int IPG = 0
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [1:0]        cmd_type,
  input  logic [15:0]       cmd_count,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [DW-1:0]     axis_tx_tdata,
  output logic [DW/8-1:0]   axis_tx_tkeep,
  output logic              axis_tx_tlast,
  output logic              axis_tx_tvalid,
  input  logic              axis_tx_tready,
  output logic              busy,
  output logic              cmd_error,
  output logic [31:0]       fd_sent,
  output logic [31:0]       md_sent,
  output logic [31:0]       fc_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e          state, next_state;
  pkt_type_e       pkt_type;
  logic [15:0]     remaining;
  logic [7:0]      beat_idx;
  logic [7:0]      gap_cnt;
  logic [31:0]     seq;
  logic [DW-1:0]   fmt_data;
  logic [DW/8-1:0] fmt_keep;
  logic            fmt_last;
  logic            fire, pkt_done, cmd_ok, gap_done;

  ns_txpkt_beat_fmt #(.DW(DW)) u_fmt (
    .pkt_type (pkt_type),
    .beat_idx (beat_idx),
    .seq      (seq),
    .tdata    (fmt_data),
    .tkeep    (fmt_keep),
    .tlast    (fmt_last)
  );

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign axis_tx_tvalid = (state == SEND);
  // Outputs are zero outside SEND so reset clears them without waiting for a clock.
  assign axis_tx_tdata  = axis_tx_tvalid ? fmt_data : '0;
  assign axis_tx_tkeep  = axis_tx_tvalid ? fmt_keep : '0;
  assign axis_tx_tlast  = axis_tx_tvalid & fmt_last;

  assign fire     = axis_tx_tvalid & axis_tx_tready;
  assign pkt_done = fire & fmt_last;
  assign cmd_ok   = cmd_valid && (cmd_type != 2'd3) && (cmd_count != 16'd0);
  assign gap_done = (gap_cnt == 8'(IPG - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cmd_ok) next_state = SEND;
      SEND: begin
        if (pkt_done) begin
          if (IPG > 0)                  next_state = GAP;
          else if (remaining == 16'd1)  next_state = IDLE;
        end
      end
      GAP:  if (gap_done) next_state = (remaining != 16'd0) ? SEND : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pkt_type  <= PKT_FD;
      remaining <= 16'd0;
      beat_idx  <= 8'd0;
      gap_cnt   <= 8'd0;
      seq       <= 32'd0;
      cmd_error <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        if (cmd_type == 2'd3) begin
          cmd_error <= 1'b1;
        end else begin
          pkt_type  <= pkt_type_e'(cmd_type);
          remaining <= cmd_count;
          beat_idx  <= 8'd0;
        end
      end
      if (fire) begin
        if (fmt_last) begin
          beat_idx  <= 8'd0;
          remaining <= remaining - 16'd1;
          seq       <= seq + 32'd1;
        end else begin
          beat_idx  <= beat_idx + 8'd1;
        end
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

`ifdef NS_TXPKT_STATS_EN
  logic [31:0] fd_q, md_q, fc_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fd_q <= 32'd0;
      md_q <= 32'd0;
      fc_q <= 32'd0;
    end else if (pkt_done) begin
      case (pkt_type)
        PKT_FD:  fd_q <= fd_q + 32'd1;
        PKT_MD:  md_q <= md_q + 32'd1;
        PKT_FC:  fc_q <= fc_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign fd_sent = fd_q;
  assign md_sent = md_q;
  assign fc_sent = fc_q;
`else
  assign fd_sent = 32'd0;
  assign md_sent = 32'd0;
  assign fc_sent = 32'd0;
`endif

endmodule
